stream_mux_n_1: RTL and testbench
=================================

# stream_mux_n_1

Parametrised N-to-1 multiplexer for W-bit valid/ready streams with a registered output stage. It is the successor to the 2:1 combinational bit mux. It adds the following:
- width and channel-count parameters;
- per-channel handshakes;
- a round-robin mode alongside externally selected steering;
- a one-deep output register that sustains one beat per cycle under back-pressure.

It sits between multiple producers and a single consumer in the datapath.

## Interface
- `N`, default 4: number of input channels, 2..16.
- `W`, default 8: data width per channel, ≥1.
- `SW`, default `$clog2(N)`: select width (derived, not overridden).

Ports:
- `clk`: input, 1 bit. Rising-edge clock; the block has one clock.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `in_data`: input, N*W bits. Channel i occupies bits [i*W +: W].
- `in_valid`: input, N bits. Per-channel valid.
- `in_ready`: output, N bits. Per-channel ready.
- `sel`: input, SW bits. Channel select, used in fixed mode.
- `mode`: input, 1 bit. 0 = fixed select, 1 = round-robin.
- `out_data`: output, W bits. Registered output data.
- `out_valid`: output, 1 bit. Output holds a beat.
- `out_ready`: input, 1 bit. Consumer accepts.
- `out_count`: output, 16 bits. Only present with `STREAM_MUX_COUNT_EN` (see Configuration).

## Operation
- Reset values:
  - `out_valid` = 0.
  - `out_data` = 0.
  - Round-robin pointer `rr_ptr` = 0.
  - `out_count` = 0.
  - `in_ready` is forced to all-zero while `rst` is high.
- Load enable: `accept` = `!out_valid || out_ready`, evaluated combinationally.
- Fixed mode (`mode`=0):
  - The candidate channel is `sel`.
  - If `sel` ≥ N, there is no candidate and every `in_ready` is 0.
- Round-robin mode (`mode`=1):
  - The candidate is the first channel with `in_valid` set, searching from `rr_ptr` upward and wrapping from N-1 to 0.
  - If no channel is valid, there is no candidate.
- `in_ready[i]` = `accept` && (i == candidate) && !`rst`. At most one bit of `in_ready` is ever high.
- Transfer: occurs on channel c when `in_valid[c]` && `in_ready[c]`. On that edge:
  - `out_data` <= the channel's data.
  - `out_valid` <= 1.
- Drain: if `out_valid` && `out_ready` and there is no transfer on the same edge, `out_valid` <= 0. `out_data` holds its last value.
- Simultaneous drain and load: the register is replaced and `out_valid` stays 1. No bubble is inserted.
- `rr_ptr` update:
  - On a round-robin transfer, `rr_ptr` <= (c+1) mod N.
  - `rr_ptr` is unchanged by fixed-mode transfers and by idle cycles.
- Mode or `sel` changes take effect on the next candidate evaluation. A beat already in the output register is never altered or dropped.
- A beat in the output register with `out_ready` low holds indefinitely; all `in_ready` bits are 0 during that time.
- Reset mid-operation: a beat held in the output register is discarded, and `out_valid` drops asynchronously.

## Timing
- Latency is 1 cycle: a beat transferred at edge k is visible on `out_data`/`out_valid` after edge k.
- Throughput is 1 beat per cycle when `out_ready` is held high.
- `in_ready` is combinational from `out_valid`, `out_ready`, `sel`, `mode`, `in_valid` and `rr_ptr`. There are no combinational paths from `in_data` to any output.
- Reset is asserted asynchronously and must be released synchronously to `clk` by the upstream reset synchroniser.

## Configuration
- With `STREAM_MUX_COUNT_EN` defined:
  - The `out_count` port exists.
  - It increments by 1 on every output handshake (`out_valid` && `out_ready`).
  - It wraps from 0xFFFF to 0x0000.
  - It resets to 0.
- Without the macro:
  - The port and the counter logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use N=4 and W=8.
- **Fixed mode:** `sel`=2, `in_valid`=4'b0100, `in_data` ch2=0xA5, `out_ready`=1 → `in_ready`=4'b0100; `out_data`=0xA5 and `out_valid`=1 one cycle later. Other channels are never ready.
- **Back-pressure:** hold `out_ready`=0 after load 0x11, then offer 0x22 → `in_ready`=0, `out_data` stays 0x11. Raise `out_ready` → 0x22 loads on the same edge that drains 0x11, and `out_valid` stays 1.
- **Round-robin:** all four channels valid continuously with data 0x10..0x13, `out_ready`=1 → output sequence 0x10, 0x11, 0x12, 0x13, 0x10 at one beat per cycle. With only ch1 and ch3 valid → alternates 1, 3, 1, 3.
- **Out-of-range or idle:** fixed mode with `sel`=3 and `in_valid[3]`=0 → no transfer. Round-robin with `in_valid`=0 → `rr_ptr` unchanged, and `out_valid` falls after the drain.
- **Reset mid-stream:** assert `rst` while `out_valid`=1 with `out_data`=0x5A → `out_valid` and `out_data` go to 0 immediately, `in_ready`=0, `rr_ptr`=0. After release the first round-robin grant goes to ch0.
- **Counter (with `STREAM_MUX_COUNT_EN`):** 65537 output handshakes from reset → `out_count`=0x0001.

Source files
------------

// File: rtl/stream_mux_n_1.sv
// stream_mux_n_1
//
// N-to-1 multiplexer for W-bit valid/ready streams with a one-deep registered
// output stage. The source channel is either chosen externally through 'sel'
// (fixed mode) or by a round-robin search over the valid channels starting at
// an internal pointer (round-robin mode). The output register can be drained
// and reloaded on the same edge, so one beat per cycle is sustained while the
// consumer keeps out_ready high.
//
// Parameters:
//   N  - number of input channels (2..16)
//   W  - data width per channel (>= 1)
//   SW - select width, derived as $clog2(N)
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   in_data    - N*W bits, channel i at [i*W +: W]
//   in_valid   - per-channel valid
//   in_ready   - per-channel ready (at most one bit high, all zero in reset)
//   sel        - channel select used in fixed mode
//   mode       - 0 = fixed select, 1 = round-robin
//   out_data   - registered output data
//   out_valid  - output register holds a beat
//   out_ready  - consumer accepts the output beat
//   out_count  - 16-bit output handshake counter (optional)
//
// Optional feature: define STREAM_MUX_COUNT_EN to add the out_count port and
// its wrapping handshake counter. Without it the port and counter are absent.

module stream_mux_n_1 #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready
`ifdef STREAM_MUX_COUNT_EN
  ,
  output logic [15:0]    out_count
`endif
);

  logic [W-1:0]  outData_q, outData_d;
  logic          outValid_q, outValid_d;
  logic [SW-1:0] rrPtr_q, rrPtr_d;

  logic          accept;
  logic          candValid;
  logic [SW-1:0] candIdx;
  logic [N-1:0]  inReady;
  logic          transfer;
  logic [W-1:0]  selData;

  // Channel index (base + offset) wrapped into 0..N-1; offset is at most N-1.
  function automatic logic [SW-1:0] wrapIdx(input logic [SW-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= N) s = s - N;
    return SW'(s);
  endfunction

  // The output register can take a new beat when it is empty or being drained.
  assign accept = !outValid_q || out_ready;

  // Candidate selection. Fixed mode trusts 'sel' unless it points past the
  // last channel. Round-robin takes the first valid channel at or after the
  // pointer, wrapping around, so no candidate exists when nothing is valid.
  always_comb begin
    candValid = 1'b0;
    candIdx   = '0;
    if (!mode) begin
      if (int'(sel) < N) begin
        candValid = 1'b1;
        candIdx   = sel;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!candValid && in_valid[wrapIdx(rrPtr_q, k)]) begin
          candValid = 1'b1;
          candIdx   = wrapIdx(rrPtr_q, k);
        end
      end
    end
  end

  // One-hot ready towards the candidate only; reset forces all readies low
  // even before the first clock edge sees it.
  always_comb begin
    inReady = '0;
    for (int i = 0; i < N; i++) begin
      inReady[i] = accept && candValid && (candIdx == SW'(i)) && !rst;
    end
  end

  assign in_ready = inReady;
  assign transfer = |(inReady & in_valid);

  // Data steering; in_data only reaches the output register, never a port.
  always_comb begin
    selData = '0;
    for (int i = 0; i < N; i++) begin
      if (candIdx == SW'(i)) selData = in_data[i*W +: W];
    end
  end

  // Next-state: a transfer always wins and keeps out_valid high, which is
  // what allows drain-and-reload on one edge without a bubble. The pointer
  // only moves on round-robin transfers, to just past the granted channel.
  always_comb begin
    outData_d  = outData_q;
    outValid_d = outValid_q;
    rrPtr_d    = rrPtr_q;
    if (transfer) begin
      outData_d  = selData;
      outValid_d = 1'b1;
      if (mode) rrPtr_d = wrapIdx(candIdx, 1);
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outData_q  <= '0;
      outValid_q <= 1'b0;
      rrPtr_q    <= '0;
    end else begin
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;

`ifdef STREAM_MUX_COUNT_EN
  logic [15:0] count_q, count_d;

  // Counts output handshakes; natural 16-bit wrap from 0xFFFF to 0.
  always_comb begin
    count_d = count_q;
    if (outValid_q && out_ready) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_stream_mux_n_1.sv
// tb_stream_mux_n_1
//
// Directed bench for stream_mux_n_1 with N=4, W=8. Inputs are driven 1 time
// unit after the rising edge; combinational in_ready is checked after inputs
// settle, registered outputs are checked 1 time unit after the edge.
// Expected values are hand-computed constants for each vector.
// With STREAM_MUX_COUNT_EN defined the handshake counter is also exercised.

module tb_stream_mux_n_1;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] inData;
  logic [N-1:0]   inValid;
  logic [N-1:0]   inReady;
  logic [SW-1:0]  sel;
  logic           mode;
  logic [W-1:0]   outData;
  logic           outValid;
  logic           outReady;
`ifdef STREAM_MUX_COUNT_EN
  logic [15:0]    outCount;
`endif

  int checkCount;
  int errorCount;

  stream_mux_n_1 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .sel       (sel),
    .mode      (mode),
    .out_data  (outData),
    .out_valid (outValid),
    .out_ready (outReady)
`ifdef STREAM_MUX_COUNT_EN
    ,
    .out_count (outCount)
`endif
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the control inputs for the coming cycle and let them settle.
  task automatic applyStimulus(input logic m, input logic [SW-1:0] s,
                               input logic [N-1:0] v, input logic r);
    mode     = m;
    sel      = s;
    inValid  = v;
    outReady = r;
    #1;
  endtask

  task automatic setData(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
    inData = {d3, d2, d1, d0};
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rrSeq [5];
  logic [7:0] altSeq [4];

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    setData(8'h01, 8'h02, 8'h03, 8'h04);
    applyStimulus(1'b0, 2'd0, 4'b1111, 1'b1);

    // Reset state: outputs cleared and every ready forced low.
    checkOutput("reset out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("reset out_data", {24'd0, outData}, 32'd0);
    checkOutput("reset in_ready", {28'd0, inReady}, 32'd0);
    stepClock();
    stepClock();
    rst = 1'b0;

    // Fixed mode, sel=2, only ch2 valid.
    setData(8'h01, 8'h02, 8'hA5, 8'h03);
    applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1);
    checkOutput("fixed in_ready", {28'd0, inReady}, 32'h4);
    stepClock();
    checkOutput("fixed out_data", {24'd0, outData}, 32'hA5);
    checkOutput("fixed out_valid", {31'd0, outValid}, 32'd1);
    applyStimulus(1'b0, 2'd2, 4'b0000, 1'b1);
    stepClock();
    checkOutput("fixed drain valid", {31'd0, outValid}, 32'd0);
    checkOutput("fixed drain data", {24'd0, outData}, 32'hA5);

    // Back-pressure on ch0.
    setData(8'h11, 8'h02, 8'h03, 8'h04);
    applyStimulus(1'b0, 2'd0, 4'b0001, 1'b0);
    checkOutput("bp first ready", {28'd0, inReady}, 32'h1);
    stepClock();
    checkOutput("bp load data", {24'd0, outData}, 32'h11);
    setData(8'h22, 8'h02, 8'h03, 8'h04);
    #1;
    checkOutput("bp stalled ready", {28'd0, inReady}, 32'h0);
    stepClock();
    checkOutput("bp hold data", {24'd0, outData}, 32'h11);
    checkOutput("bp hold valid", {31'd0, outValid}, 32'd1);
    stepClock();
    checkOutput("bp hold data 2", {24'd0, outData}, 32'h11);
    applyStimulus(1'b0, 2'd0, 4'b0001, 1'b1);
    checkOutput("bp release ready", {28'd0, inReady}, 32'h1);
    stepClock();
    checkOutput("bp reload data", {24'd0, outData}, 32'h22);
    checkOutput("bp reload valid", {31'd0, outValid}, 32'd1);
    applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
    stepClock();
    checkOutput("bp final drain", {31'd0, outValid}, 32'd0);

    // Round-robin, all channels valid; pointer is still 0 from reset.
    rrSeq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    setData(8'h10, 8'h11, 8'h12, 8'h13);
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    checkOutput("rr first ready", {28'd0, inReady}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      stepClock();
      checkOutput($sformatf("rr all beat%0d", i), {24'd0, outData}, {24'd0, rrSeq[i]});
      checkOutput($sformatf("rr all valid%0d", i), {31'd0, outValid}, 32'd1);
    end

    // Only ch1 and ch3 valid, pointer now at 1.
    altSeq = '{8'h11, 8'h13, 8'h11, 8'h13};
    applyStimulus(1'b1, 2'd0, 4'b1010, 1'b1);
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOutput($sformatf("rr alt beat%0d", i), {24'd0, outData}, {24'd0, altSeq[i]});
    end

    // Single grant to ch1 moves the pointer to 2.
    applyStimulus(1'b1, 2'd0, 4'b0010, 1'b1);
    checkOutput("rr single ready", {28'd0, inReady}, 32'h2);
    stepClock();
    checkOutput("rr single data", {24'd0, outData}, 32'h11);

    // Fixed sel=3 with ch3 not valid: ready offered but no transfer, drain.
    applyStimulus(1'b0, 2'd3, 4'b0111, 1'b1);
    checkOutput("idle fixed ready", {28'd0, inReady}, 32'h8);
    stepClock();
    checkOutput("idle fixed valid", {31'd0, outValid}, 32'd0);
    checkOutput("idle fixed data", {24'd0, outData}, 32'h11);

    // Round-robin with nothing valid: no grant, pointer must stay at 2.
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
    checkOutput("idle rr ready", {28'd0, inReady}, 32'h0);
    stepClock();
    stepClock();
    checkOutput("idle rr valid", {31'd0, outValid}, 32'd0);
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    checkOutput("rr resume ready", {28'd0, inReady}, 32'h4);
    stepClock();
    checkOutput("rr resume data", {24'd0, outData}, 32'h12);

    // Reset mid-stream with 0x5A held under back-pressure.
    setData(8'h5A, 8'h11, 8'h12, 8'h13);
    applyStimulus(1'b0, 2'd0, 4'b0001, 1'b1);
    stepClock();
    checkOutput("pre-reset data", {24'd0, outData}, 32'h5A);
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async reset valid", {31'd0, outValid}, 32'd0);
    checkOutput("async reset data", {24'd0, outData}, 32'd0);
    checkOutput("async reset ready", {28'd0, inReady}, 32'h0);
    stepClock();
    rst = 1'b0;
    setData(8'h10, 8'h11, 8'h12, 8'h13);
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    checkOutput("post-reset ready", {28'd0, inReady}, 32'h1);
    stepClock();
    checkOutput("post-reset data", {24'd0, outData}, 32'h10);

`ifdef STREAM_MUX_COUNT_EN
    // Counter: 65537 handshakes from reset must wrap to 1.
    rst = 1'b1;
    #1;
    checkOutput("count reset", {16'd0, outCount}, 32'd0);
    stepClock();
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 4'b0001, 1'b1);
    // First edge only loads; each of the following 65537 edges is a handshake.
    for (int i = 0; i < 65538; i++) begin
      stepClock();
    end
    checkOutput("count wrap", {16'd0, outCount}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
